// File: rtl/aes_pkg.sv
// Shared AES types: engine opcodes, 128-bit operand type, scheduler FSM states.
// Pure declarations; no timing or backpressure of its own.
package aes_pkg;

    typedef logic [127:0] aes_128;

    typedef enum logic [2:0] {
        NOOP            = 3'd0,
        AESENC          = 3'd1,
        AESENCLAST      = 3'd2,
        AESDEC          = 3'd3,
        AESDECLAST      = 3'd4,
        AESKEYGENASSIST = 3'd5,
        AESIMC          = 3'd6
    } opcode;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_e;

    // Key-generation completes on the engine's key_ready pulse, everything else on cipher_ready.
    function automatic logic uses_key_ready(input opcode op);
        return op == AESKEYGENASSIST;
    endfunction

endpackage

// File: rtl/aes_req_sched_if.sv
// Requester-side request/response bundle of the AES scheduler.
// Valid/ready on both channels; slave is the scheduler, master the requesters.
interface aes_req_sched_if #(
    parameter int N_REQ = 4
);
    import aes_pkg::*;

    logic   [N_REQ-1:0] req_valid_i;
    logic   [N_REQ-1:0] req_ready_o;
    opcode  [N_REQ-1:0] req_op_i;
    aes_128 [N_REQ-1:0] req_state_i;
    aes_128 [N_REQ-1:0] req_key_i;

    logic   [N_REQ-1:0] rsp_valid_o;
    logic   [N_REQ-1:0] rsp_ready_i;
    aes_128             rsp_data_o;
    logic               rsp_err_o;

    modport master (
        output req_valid_i, req_op_i, req_state_i, req_key_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_state_i, req_key_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

endinterface

// File: rtl/aes_rr_arb.sv
// Round-robin priority picker: first set request at or after rr_ptr wins. Combinational.
// No backpressure; the caller decides whether the grant is used.
module aes_rr_arb #(
    parameter  int N_REQ = 4,
    localparam int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PW-1:0]    gnt_idx,
    output logic             gnt_any
);

    logic [PW:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // rr_ptr < N_REQ and i < N_REQ, so one subtraction is a full modulo.
            cand = {1'b0, rr_ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(N_REQ)) begin
                cand = cand - (PW+1)'(N_REQ);
            end
            if (!gnt_any && req[cand[PW-1:0]]) begin
                gnt_any                = 1'b1;
                gnt_idx                = cand[PW-1:0];
                gnt[cand[PW-1:0]]      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_req_sched.sv
// Round-robin sharing of one AES engine; start 1 cycle after accept, response 1 cycle after engine ready.
// One request in flight; req_ready is low outside IDLE and the response is held until its ready.
module aes_req_sched
    import aes_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           nrst,
    aes_req_sched_if.slave req_if,
    output logic           core_start_o,
    output opcode          core_opcode_o,
    output aes_128         core_state_o,
    output aes_128         core_key_o,
    input  logic           core_cipher_ready_i,
    input  logic           core_key_ready_i,
    input  aes_128         core_result_i,
    output logic           busy_o
);

    localparam int PW = $clog2(N_REQ);
    localparam int WW = $clog2(TIMEOUT);

    sched_state_e   state_q, state_d;
    logic [PW-1:0]  rr_ptr_q, gnt_idx_q, arb_idx;
    logic [N_REQ-1:0] arb_gnt;
    logic           arb_any;
    opcode          op_q, arb_op;
    aes_128         st_q, key_q, data_q;
    logic           err_q;
    logic [WW-1:0]  wd_q;
    logic           accept, done, timeout;

    aes_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req     (req_if.req_valid_i),
        .rr_ptr  (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign arb_op  = opcode'(req_if.req_op_i[arb_idx]);
    assign done    = uses_key_ready(op_q) ? core_key_ready_i : core_cipher_ready_i;
    assign timeout = (wd_q == WW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    accept  = 1'b1;
                    state_d = (arb_op == NOOP) ? RESP : ISSUE;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    if (done || timeout) state_d = RESP;
            RESP:    if (req_if.rsp_ready_i[gnt_idx_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rr_ptr_q  <= '0;
            gnt_idx_q <= '0;
            op_q      <= NOOP;
            st_q      <= '0;
            key_q     <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            wd_q      <= '0;
        end else begin
            if (accept) begin
                gnt_idx_q <= arb_idx;
                op_q      <= arb_op;
                st_q      <= req_if.req_state_i[arb_idx];
                key_q     <= req_if.req_key_i[arb_idx];
                rr_ptr_q  <= (arb_idx == PW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                if (arb_op == NOOP) begin
                    data_q <= '0;
                    err_q  <= 1'b1;
                end
            end
            if (state_q == ISSUE) begin
                wd_q <= '0;
            end else if (state_q == WAIT) begin
                wd_q <= wd_q + 1'b1;
                // Completion takes priority over a coincident timeout.
                if (done) begin
                    data_q <= core_result_i;
                    err_q  <= 1'b0;
                end else if (timeout) begin
                    data_q <= '0;
                    err_q  <= 1'b1;
                end
            end
        end
    end

    assign req_if.req_ready_o = (state_q == IDLE && nrst) ? arb_gnt : '0;
    assign req_if.rsp_valid_o = (state_q == RESP) ? (N_REQ'(1) << gnt_idx_q) : '0;
    assign req_if.rsp_data_o  = data_q;
    assign req_if.rsp_err_o   = err_q;

    assign core_start_o  = (state_q == ISSUE);
    assign core_opcode_o = (state_q == ISSUE || state_q == WAIT) ? op_q : NOOP;
    assign core_state_o  = st_q;
    assign core_key_o    = key_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_aes_req_sched.sv
// Bench for aes_req_sched: directed scenarios plus randomized traffic against a round-robin model.
module tb_aes_req_sched;
    import aes_pkg::*;

    localparam int N  = 4;
    localparam int TO = 64;

    logic   clk = 1'b0;
    logic   nrst;
    logic   core_start, cr, kr, busy;
    opcode  core_op;
    aes_128 core_state, core_key, core_res;

    always #5 clk = ~clk;

    aes_req_sched_if #(.N_REQ(N)) rif ();

    aes_req_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk                 (clk),
        .nrst                (nrst),
        .req_if              (rif),
        .core_start_o        (core_start),
        .core_opcode_o       (core_op),
        .core_state_o        (core_state),
        .core_key_o          (core_key),
        .core_cipher_ready_i (cr),
        .core_key_ready_i    (kr),
        .core_result_i       (core_res),
        .busy_o              (busy)
    );

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    function automatic int exp_grant(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic aes_128 rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        rif.req_valid_i = '0; rif.rsp_ready_i = '0;
        cr = 1'b0; kr = 1'b0; core_res = '0;
        for (int i = 0; i < N; i++) begin
            rif.req_op_i[i] = NOOP; rif.req_state_i[i] = '0; rif.req_key_i[i] = '0;
        end
        repeat (2) step();
        checks++; if ({rif.req_ready_o, rif.rsp_valid_o, core_start, rif.rsp_err_o, busy} !== '0) begin errors++; $display("FAIL reset_ctrl got %b exp 0", {rif.req_ready_o, rif.rsp_valid_o, core_start, rif.rsp_err_o, busy}); end
        checks++; if (core_op !== NOOP) begin errors++; $display("FAIL reset_opcode got %0d exp 0", core_op); end
        checks++; if ({core_state, core_key, rif.rsp_data_o} !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", {core_state, core_key, rif.rsp_data_o}); end
        nrst = 1'b1;
        ptr_m = 0;
        step();
    endtask

    task automatic test_rr();
        int g; opcode op; aes_128 st, res; logic [N-1:0] er;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) begin
                rif.req_op_i[i] = opcode'($urandom_range(4, 1));
                rif.req_state_i[i] = rnd128(); rif.req_key_i[i] = rnd128();
            end
            rif.req_valid_i = '1;
            #1;
            g = exp_grant(rif.req_valid_i, ptr_m); er = N'(1) << g;
            op = opcode'(rif.req_op_i[g]); st = rif.req_state_i[g];
            checks++; if (rif.req_ready_o !== er) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", k, rif.req_ready_o, er); end
            step(); ptr_m = (g + 1) % N;
            checks++; if ({core_start, core_op, core_state} !== {1'b1, op, st}) begin errors++; $display("FAIL rr_start%0d got %b/%0d exp 1/%0d", k, core_start, core_op, op); end
            step();
            repeat ($urandom_range(5, 0)) step();
            checks++; if (rif.req_ready_o !== '0) begin errors++; $display("FAIL rr_ready_wait%0d got %b exp 0", k, rif.req_ready_o); end
            res = rnd128(); core_res = res; cr = 1'b1; step(); cr = 1'b0;
            checks++; if ({rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o} !== {er, 1'b0, res}) begin errors++; $display("FAIL rr_rsp%0d got %b %b %h exp %b 0 %h", k, rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o, er, res); end
            rif.rsp_ready_i = '1; step(); rif.rsp_ready_i = '0;
        end
        rif.req_valid_i = '0;
    endtask

    task automatic test_single();
        aes_128 st, key, a5;
        st = rnd128(); key = rnd128(); a5 = {16{8'hA5}};
        rif.req_op_i[2] = AESENC; rif.req_state_i[2] = st; rif.req_key_i[2] = key;
        rif.req_valid_i = 4'b0100;
        #1;
        checks++; if (rif.req_ready_o !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", rif.req_ready_o); end
        step(); rif.req_valid_i = '0; ptr_m = 3;
        checks++; if ({core_start, core_op, core_state, core_key} !== {1'b1, AESENC, st, key}) begin errors++; $display("FAIL single_start got %b op %0d exp 1 op %0d", core_start, core_op, AESENC); end
        step();
        checks++; if ({core_start, busy, core_op, core_state} !== {1'b0, 1'b1, AESENC, st}) begin errors++; $display("FAIL single_wait_hold got %b %b %0d exp 0 1 %0d", core_start, busy, core_op, AESENC); end
        core_res = a5; cr = 1'b1; step(); cr = 1'b0; core_res = rnd128();
        checks++; if ({rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o} !== {4'b0100, 1'b0, a5}) begin errors++; $display("FAIL single_rsp got %b %b %h exp 0100 0 a5..", rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o); end
        rif.rsp_ready_i = 4'b0100; step(); rif.rsp_ready_i = '0;
        checks++; if ({rif.rsp_valid_o, busy} !== '0) begin errors++; $display("FAIL single_done got %b exp 0", {rif.rsp_valid_o, busy}); end
    endtask

    task automatic test_keygen();
        aes_128 res;
        rif.req_op_i[1] = AESKEYGENASSIST; rif.req_state_i[1] = rnd128(); rif.req_key_i[1] = rnd128();
        rif.req_valid_i = 4'b0010;
        #1;
        checks++; if (rif.req_ready_o !== 4'b0010) begin errors++; $display("FAIL kg_ready got %b exp 0010", rif.req_ready_o); end
        step(); rif.req_valid_i = '0; ptr_m = 2;
        checks++; if ({core_start, core_op} !== {1'b1, AESKEYGENASSIST}) begin errors++; $display("FAIL kg_start got %b %0d", core_start, core_op); end
        step();
        core_res = rnd128(); cr = 1'b1; step(); cr = 1'b0;
        checks++; if ({rif.rsp_valid_o, busy} !== {4'b0000, 1'b1}) begin errors++; $display("FAIL kg_wrong_pulse got %b exp 00001", {rif.rsp_valid_o, busy}); end
        repeat (3) step();
        res = rnd128(); core_res = res; kr = 1'b1; step(); kr = 1'b0;
        checks++; if ({rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o} !== {4'b0010, 1'b0, res}) begin errors++; $display("FAIL kg_rsp got %b %b %h exp 0010 0 %h", rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o, res); end
        rif.rsp_ready_i = 4'b0010; step(); rif.rsp_ready_i = '0;
    endtask

    task automatic test_timeout();
        int cyc; bit seen;
        rif.req_op_i[3] = AESENC; rif.req_state_i[3] = rnd128(); rif.req_key_i[3] = rnd128();
        rif.req_valid_i = 4'b1000;
        step(); rif.req_valid_i = '0; ptr_m = 0;
        checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL to_start got %b exp 1", core_start); end
        cyc = 0; seen = 1'b0;
        for (int i = 1; i <= TO + 8 && !seen; i++) begin
            step();
            if (rif.rsp_valid_o !== '0) begin seen = 1'b1; cyc = i; end
        end
        checks++; if (cyc != TO + 1) begin errors++; $display("FAIL to_latency got %0d exp %0d", cyc, TO + 1); end
        checks++; if ({rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o} !== {4'b1000, 1'b1, 128'h0}) begin errors++; $display("FAIL to_rsp got %b %b %h exp 1000 1 0", rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o); end
        core_res = rnd128(); cr = 1'b1; step(); cr = 1'b0; kr = 1'b1; step(); kr = 1'b0;
        checks++; if ({rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o} !== {4'b1000, 1'b1, 128'h0}) begin errors++; $display("FAIL to_late_pulse got %b %b %h exp 1000 1 0", rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o); end
        rif.rsp_ready_i = 4'b1000; step(); rif.rsp_ready_i = '0;
    endtask

    task automatic test_timeout_race();
        aes_128 res;
        rif.req_op_i[0] = AESDECLAST; rif.req_state_i[0] = rnd128(); rif.req_key_i[0] = rnd128();
        rif.req_valid_i = 4'b0001;
        step(); rif.req_valid_i = '0; ptr_m = 1;
        repeat (TO) step();
        checks++; if (rif.rsp_valid_o !== '0) begin errors++; $display("FAIL race_early got %b exp 0", rif.rsp_valid_o); end
        res = rnd128(); core_res = res; cr = 1'b1; step(); cr = 1'b0;
        checks++; if ({rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o} !== {4'b0001, 1'b0, res}) begin errors++; $display("FAIL race_rsp got %b %b %h exp 0001 0 %h", rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o, res); end
        rif.rsp_ready_i = 4'b0001; step(); rif.rsp_ready_i = '0;
    endtask

    task automatic test_noop();
        rif.req_op_i[0] = NOOP; rif.req_valid_i = 4'b0001;
        #1;
        checks++; if (rif.req_ready_o !== 4'b0001) begin errors++; $display("FAIL noop_ready got %b exp 0001", rif.req_ready_o); end
        step(); rif.req_valid_i = '0; ptr_m = 1;
        checks++; if ({core_start, core_op, rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o} !== {1'b0, NOOP, 4'b0001, 1'b1, 128'h0}) begin errors++; $display("FAIL noop_rsp got %b %0d %b %b %h", core_start, core_op, rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o); end
        rif.rsp_ready_i = 4'b0001; step(); rif.rsp_ready_i = '0;
        rif.req_valid_i = '1;
        #1;
        checks++; if (rif.req_ready_o !== 4'b0010) begin errors++; $display("FAIL noop_ptr got %b exp 0010", rif.req_ready_o); end
        rif.req_valid_i = '0;
        step();
    endtask

    task automatic test_backpressure_reset();
        aes_128 res;
        rif.req_op_i[2] = AESDEC; rif.req_state_i[2] = rnd128(); rif.req_key_i[2] = rnd128();
        rif.req_valid_i = 4'b0100;
        step(); rif.req_valid_i = '0; step();
        res = rnd128(); core_res = res; cr = 1'b1; step(); cr = 1'b0;
        rif.req_valid_i = '1;
        for (int i = 0; i < 10; i++) begin
            rif.rsp_ready_i = 4'b1011 & N'($urandom);
            core_res = rnd128(); cr = 1'($urandom); kr = 1'($urandom);
            step();
            checks++; if ({rif.req_ready_o, rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o} !== {4'b0000, 4'b0100, 1'b0, res}) begin errors++; $display("FAIL bp_hold%0d got %b %b %b %h exp 0000 0100 0 %h", i, rif.req_ready_o, rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o, res); end
        end
        cr = 1'b0; kr = 1'b0; rif.rsp_ready_i = '0;
        nrst = 1'b0;
        step();
        checks++; if ({rif.req_ready_o, rif.rsp_valid_o, core_start, rif.rsp_err_o, busy} !== '0) begin errors++; $display("FAIL bp_reset_ctrl got %b exp 0", {rif.req_ready_o, rif.rsp_valid_o, core_start, rif.rsp_err_o, busy}); end
        checks++; if ({core_op, core_state, core_key, rif.rsp_data_o} !== '0) begin errors++; $display("FAIL bp_reset_data got nonzero opcode/operands/data"); end
        nrst = 1'b1; ptr_m = 0;
        #1;
        checks++; if (rif.req_ready_o !== 4'b0001) begin errors++; $display("FAIL bp_reset_ptr got %b exp 0001", rif.req_ready_o); end
        rif.req_valid_i = '0;
        step();
    endtask

    task automatic test_random();
        logic [N-1:0] v, er; int g; opcode op; aes_128 st, key, res;
        for (int t = 0; t < 40; t++) begin
            v = N'($urandom_range(15, 1));
            for (int i = 0; i < N; i++) begin
                rif.req_op_i[i] = opcode'($urandom_range(6, 0));
                rif.req_state_i[i] = rnd128(); rif.req_key_i[i] = rnd128();
            end
            rif.req_valid_i = v;
            #1;
            g = exp_grant(v, ptr_m); er = N'(1) << g;
            op = opcode'(rif.req_op_i[g]); st = rif.req_state_i[g]; key = rif.req_key_i[g];
            checks++; if (rif.req_ready_o !== er) begin errors++; $display("FAIL rnd_grant%0d got %b exp %b", t, rif.req_ready_o, er); end
            step(); ptr_m = (g + 1) % N;
            rif.req_valid_i = N'($urandom);
            if (op == NOOP) begin
                checks++; if ({core_start, rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o} !== {1'b0, er, 1'b1, 128'h0}) begin errors++; $display("FAIL rnd_noop%0d got %b %b %b", t, core_start, rif.rsp_valid_o, rif.rsp_err_o); end
            end else begin
                checks++; if ({core_start, core_op, core_state, core_key} !== {1'b1, op, st, key}) begin errors++; $display("FAIL rnd_start%0d got %b %0d exp 1 %0d", t, core_start, core_op, op); end
                step();
                repeat ($urandom_range(6, 0)) begin
                    if ($urandom_range(1, 0) == 1) begin
                        if (op == AESKEYGENASSIST) cr = 1'b1; else kr = 1'b1;
                    end
                    core_res = rnd128(); step(); cr = 1'b0; kr = 1'b0;
                end
                checks++; if ({rif.req_ready_o, rif.rsp_valid_o, busy} !== {4'b0000, 4'b0000, 1'b1}) begin errors++; $display("FAIL rnd_wait%0d got %b %b %b", t, rif.req_ready_o, rif.rsp_valid_o, busy); end
                res = rnd128(); core_res = res;
                if (op == AESKEYGENASSIST) kr = 1'b1; else cr = 1'b1;
                step(); cr = 1'b0; kr = 1'b0; core_res = rnd128();
                checks++; if ({rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o} !== {er, 1'b0, res}) begin errors++; $display("FAIL rnd_rsp%0d got %b %b %h exp %b 0 %h", t, rif.rsp_valid_o, rif.rsp_err_o, rif.rsp_data_o, er, res); end
            end
            repeat ($urandom_range(3, 0)) begin
                rif.rsp_ready_i = N'($urandom) & ~er; step();
            end
            rif.rsp_ready_i = er; step(); rif.rsp_ready_i = '0; rif.req_valid_i = '0;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_idle%0d got %b exp 0", t, busy); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_rr();
        test_single();
        test_keygen();
        test_timeout();
        test_timeout_race();
        test_noop();
        test_backpressure_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
